// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter slice: FSM state encoding,
// port owner IDs and the memory map of mainMem.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [31:0] START_ADDRESS = 32'h8002_0000;
  localparam int          MEM_SIZE      = 1048578;
  localparam logic [1:0]  ACC_WORD      = 2'b11;

endpackage

// File: rtl/arb_select.sv
// Two-way requester picker used in IDLE. Contention policy is chosen by
// ARB_ROUND_ROBIN_EN (round robin on last_owner) or fixed D-over-I priority.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t     last_owner,
`endif
  output owner_t     grant
);

  // Grant decode: bit 0 is the I port, bit 1 the D port.
  always_comb begin
    grant = OWN_I;
    case (req)
      2'b01:   grant = OWN_I;
      2'b10:   grant = OWN_D;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
      2'b11:   grant = OWN_D;
`endif
      default: grant = OWN_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D port arbiter and sequencer driving mainMem (IDLE->ISSUE->WAIT->RESP).
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of fixed D priority.
module mem_arbiter #(
  parameter int                        ADDRESS_SIZE   = 32,
  parameter int                        DATA_SIZE      = 32,
  parameter int                        ACCESS_SIZE    = 2,
  parameter logic [ADDRESS_SIZE-1:0]   START_ADDRESS  = mem_arb_pkg::START_ADDRESS,
  parameter int                        MEM_SIZE       = mem_arb_pkg::MEM_SIZE,
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  output logic [DATA_SIZE-1:0]    i_rdata,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  input  logic                    d_wren,
  input  logic [ACCESS_SIZE-1:0]  d_acc_size,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    d_done,
  output logic                    err,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy
);
  import mem_arb_pkg::*;

  localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE + 1)'(MEM_SIZE);

  // A word access must start strictly above the base and end inside memory.
  function automatic logic addr_fault(input logic [ADDRESS_SIZE-1:0] addr);
    logic [ADDRESS_SIZE:0] end_off;
    end_off = {1'b0, addr} - {1'b0, START_ADDRESS} + (ADDRESS_SIZE + 1)'(4);
    return (addr <= START_ADDRESS) || (end_off > MEM_LIMIT);
  endfunction

  state_t                   state_r;
  owner_t                   owner_r;
  owner_t                   grant_s;
  logic                     fault_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [1:0]               req_s;
  logic [ADDRESS_SIZE-1:0]  sel_addr_s;
  logic                     fault_s;

  assign req_s      = {d_req, i_req};
  assign sel_addr_s = (grant_s == OWN_D) ? d_addr : i_addr;
  assign fault_s    = addr_fault(sel_addr_s);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_r;

  arb_select u_arb_select (
    .req        (req_s),
    .last_owner (last_owner_r),
    .grant      (grant_s)
  );

  // Remember who was granted last so the next tie goes to the other port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= OWN_I;
    end else if (state_r == IDLE && (i_req || d_req)) begin
      last_owner_r <= grant_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  arb_select u_arb_select (
    .req   (req_s),
    .grant (grant_s)
  );
`endif

  // Transaction sequencer; the range check is resolved on entry to ISSUE so
  // that mem_en can be a flop that is high for the ISSUE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= OWN_I;
      fault_r      <= 1'b0;
      cnt_r        <= '0;
      mem_en       <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_d_in     <= '0;
      mem_acc_size <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      err          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req || d_req) begin
            owner_r  <= grant_s;
            mem_addr <= sel_addr_s;
            fault_r  <= fault_s;
            mem_en   <= ~fault_s;
            state_r  <= ISSUE;
            if (grant_s == OWN_D) begin
              mem_d_in     <= d_wdata;
              mem_wren     <= d_wren;
              mem_acc_size <= d_acc_size;
            end else begin
              mem_d_in     <= '0;
              mem_wren     <= 1'b0;
              mem_acc_size <= ACCESS_SIZE'(ACC_WORD);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt_r  <= '0;
          if (fault_r) begin
            err     <= 1'b1;
            state_r <= RESP;
            if (owner_r == OWN_D) d_done <= 1'b1;
            else                  i_done <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_busy) begin
            state_r <= RESP;
            if (owner_r == OWN_D) begin
              d_done  <= 1'b1;
              d_rdata <= mem_wren ? '0 : mem_d_out;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_wren ? '0 : mem_d_out;
            end
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err     <= 1'b1;
            state_r <= RESP;
            if (owner_r == OWN_D) d_done <= 1'b1;
            else                  i_done <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          i_done       <= 1'b0;
          d_done       <= 1'b0;
          i_rdata      <= '0;
          d_rdata      <= '0;
          err          <= 1'b0;
          mem_wren     <= 1'b0;
          mem_addr     <= '0;
          mem_d_in     <= '0;
          mem_acc_size <= '0;
          state_r      <= IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_wren;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_acc_size;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, d_done, err;
  logic        mem_en, mem_wren, mem_busy;
  logic [31:0] mem_addr, mem_d_in, mem_d_out;
  logic [1:0]  mem_acc_size;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Memory model state
  logic [31:0] mem_m [16] = '{default: 32'h0};
  logic [10:0] busy_left = 11'd0;
  int          busy_cycles = 0;

  // mem_en observer
  int          en_cnt = 0;
  logic        last_wren;
  logic [31:0] last_addr, last_din;
  logic [1:0]  last_acc;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
    .d_acc_size(d_acc_size), .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_acc_size(mem_acc_size),
    .mem_d_out(mem_d_out), .mem_busy(mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_d_out = mem_m[mem_addr[5:2]];
  assign mem_busy  = (busy_left != 11'd0);

  always @(posedge clk) begin
    if (mem_en) busy_left <= busy_cycles[10:0];
    else if (busy_left != 11'd0) busy_left <= busy_left - 11'd1;
    if (mem_en && mem_wren) mem_m[mem_addr[5:2]] <= mem_d_in;
  end

  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt    <= en_cnt + 1;
      last_wren <= mem_wren;
      last_addr <= mem_addr;
      last_din  <= mem_d_in;
      last_acc  <= mem_acc_size;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic port, input logic e, input logic [31:0] rd);
    exp_t x;
    x.port = port; x.err = e; x.rdata = rd;
    sb.push_back(x);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (i_done || d_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'd0, d_done, i_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", {31'd0, i_done & d_done}, 32'd0);
        chk("done_port",   {31'd0, d_done}, {31'd0, e.port});
        chk("err",         {31'd0, err}, {31'd0, e.err});
        chk("rdata",       e.port ? d_rdata : i_rdata, e.rdata);
        chk("other_rdata", e.port ? i_rdata : d_rdata, 32'd0);
      end
    end
  end

  task automatic d_txn(input logic [31:0] addr, input logic [31:0] data,
                       input logic wr, input logic [1:0] acc, output int lat);
    @(negedge clk);
    d_addr = addr; d_wdata = data; d_wren = wr; d_acc_size = acc; d_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!d_done && lat < 600);
    chk("d_done_seen", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [31:0] addr, output int lat);
    @(negedge clk);
    i_addr = addr; i_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!i_done && lat < 600);
    chk("i_done_seen", {31'd0, i_done}, 32'd1);
    i_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_d, lat_i, en0;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wren = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_acc_size = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_mem_en",  {31'd0, mem_en}, 32'd0);
    chk("rst_done",    {30'd0, i_done, d_done}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata",   i_rdata | d_rdata, 32'd0);
    rst = 1'b0;

    // D write, minimum latency
    en0 = en_cnt;
    push(1'b1, 1'b0, 32'h0);
    d_txn(32'h8002_0010, 32'hDEAD_BEEF, 1'b1, 2'b11, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_en_cycles", 32'(en_cnt - en0), 32'd1);
    chk("t1_wren", {31'd0, last_wren}, 32'd1);
    chk("t1_addr", last_addr, 32'h8002_0010);
    chk("t1_din",  last_din, 32'hDEAD_BEEF);

    // I read back
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    i_txn(32'h8002_0010, lat);
    chk("t2_latency", 32'(lat), 32'd3);
    chk("t2_wren", {31'd0, last_wren}, 32'd0);
    chk("t2_acc",  {30'd0, last_acc}, 32'd3);

    // D read with acc_size forwarded
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    d_txn(32'h8002_0010, 32'h0, 1'b0, 2'b10, lat);
    chk("t2d_acc", {30'd0, last_acc}, 32'd2);

    // Contention right after a D transaction
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h0);
`else
    push(1'b1, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
`endif
    fork
      d_txn(32'h8002_0020, 32'h1234_5678, 1'b1, 2'b11, lat_d);
      i_txn(32'h8002_0010, lat_i);
    join
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_lat_first_i", 32'(lat_i), 32'd3);
    chk("t3_lat_second_d", 32'(lat_d), 32'd7);
`else
    chk("t3_lat_first_d", 32'(lat_d), 32'd3);
    chk("t3_lat_second_i", 32'(lat_i), 32'd7);
`endif
    push(1'b0, 1'b0, 32'h1234_5678);
    i_txn(32'h8002_0020, lat);

    // Range faults: below, at base, past end; then the last valid word
    en0 = en_cnt;
    push(1'b1, 1'b1, 32'h0);
    d_txn(32'h8000_0000, 32'hAAAA_5555, 1'b1, 2'b11, lat);
    push(1'b1, 1'b1, 32'h0);
    d_txn(32'h8012_0000, 32'h0, 1'b0, 2'b11, lat);
    push(1'b1, 1'b1, 32'h0);
    d_txn(32'h8002_0000, 32'h0, 1'b0, 2'b11, lat);
    push(1'b1, 1'b1, 32'h0);
    d_txn(32'h8011_FFFF, 32'h0, 1'b0, 2'b11, lat);
    chk("t4_no_mem_en", 32'(en_cnt - en0), 32'd0);
    push(1'b1, 1'b0, 32'h0);
    d_txn(32'h8011_FFFE, 32'h0, 1'b0, 2'b11, lat);
    chk("t4_last_valid_en", 32'(en_cnt - en0), 32'd1);

    // Timeout and late busy release
    busy_cycles = 1000;
    push(1'b1, 1'b1, 32'h0);
    d_txn(32'h8002_0010, 32'h0, 1'b0, 2'b11, lat);
    chk("t5_timeout_latency", 32'(lat), 32'd257);
    busy_cycles = 5;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    d_txn(32'h8002_0010, 32'h0, 1'b0, 2'b11, lat);
    chk("t5_busy5_latency", 32'(lat), 32'd8);

    // Reset while waiting on memory, then re-serve the held request
    busy_cycles = 50;
    @(negedge clk);
    d_addr = 32'h8002_0010; d_wren = 1'b0; d_acc_size = 2'b11; d_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_pre_rst_addr", mem_addr, 32'h8002_0010);
    rst = 1'b1;
    #1;
    chk("t6_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t6_rst_done",   {30'd0, i_done, d_done}, 32'd0);
    chk("t6_rst_err",    {31'd0, err}, 32'd0);
    chk("t6_rst_addr",   mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    busy_cycles = 0;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!d_done && lat < 600);
    chk("t6_reserve_latency", 32'(lat), 32'd3);
    d_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
